// File: rtl/config_readback_if.sv
// Handshake and serial-output bundle for config_readback.
interface config_readback_if;
    logic rd_start;
    logic ser_en;
    logic sdo;
    logic sdo_valid;
    logic busy;
    logic done;

    // Requester side: starts frames and paces the serial stream
    modport master (
        output rd_start,
        output ser_en,
        input  sdo,
        input  sdo_valid,
        input  busy,
        input  done
    );

    // Readback engine side
    modport slave (
        input  rd_start,
        input  ser_en,
        output sdo,
        output sdo_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/config_readback.sv
// Serial readback of NREG configuration bytes.
// Frame layout: header 8'hA5, data bytes 0..NREG-1, then a CRC-8 (poly 0x07) over the data.
// Bits leave MSB first, one per rising edge with ser_en=1.
module config_readback #(
    parameter int unsigned NREG = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [8*NREG-1:0]   cfg_in,
    config_readback_if.slave    bus
);

    localparam int unsigned SNAP_W = 8 * NREG;
    localparam int unsigned IDX_W  = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREG - 1);
    localparam logic [7:0] HEADER_BYTE = 8'hA5;
    localparam logic [7:0] CRC_POLY    = 8'h07;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2,
        CRC    = 2'd3
    } state_e;

    state_e              state_q,    state_d;
    logic [7:0]          shift_q,    shift_d;
    logic [2:0]          bit_cnt_q,  bit_cnt_d;
    logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
    logic [7:0]          crc_q,      crc_d;
    logic [SNAP_W-1:0]   snap_q,     snap_d;
    logic                done_q,     done_d;

    logic [7:0]          crc_step_c;
    logic [IDX_W-1:0]    next_idx_c;
    logic [7:0]          next_byte_c;
    logic                last_bit_c;

    // CRC after folding in the bit currently on sdo
    always_comb begin
        crc_step_c = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ shift_q[7]) ? CRC_POLY : 8'h00);
    end

    // Snapshot byte that follows the current data byte
    always_comb begin
        next_idx_c  = byte_idx_q + IDX_W'(1);
        next_byte_c = 8'h00;
        for (int k = 0; k < int'(NREG); k++) begin
            if (IDX_W'(k) == next_idx_c) begin
                next_byte_c = snap_q[8*k +: 8];
            end
        end
    end

    // Next-state and datapath for the frame sequencer
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        crc_d      = crc_q;
        snap_d     = snap_q;
        done_d     = 1'b0;
        last_bit_c = (bit_cnt_q == 3'd7);

        case (state_q)
            IDLE: begin
                if (bus.rd_start) begin
                    snap_d     = cfg_in;
                    shift_d    = HEADER_BYTE;
                    bit_cnt_d  = 3'd0;
                    byte_idx_d = '0;
                    crc_d      = 8'h00;
                    state_d    = HEADER;
                end
            end

            HEADER: begin
                if (bus.ser_en) begin
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit_c) begin
                        shift_d    = snap_q[7:0];
                        byte_idx_d = '0;
                        state_d    = DATA;
                    end
                end
            end

            DATA: begin
                if (bus.ser_en) begin
                    crc_d     = crc_step_c;
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit_c) begin
                        if (byte_idx_q == LAST_IDX) begin
                            // CRC already includes the bit being consumed now
                            shift_d = crc_step_c;
                            state_d = CRC;
                        end else begin
                            shift_d    = next_byte_c;
                            byte_idx_d = next_idx_c;
                        end
                    end
                end
            end

            CRC: begin
                if (bus.ser_en) begin
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit_c) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            byte_idx_q <= '0;
            crc_q      <= 8'h00;
            snap_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            crc_q      <= crc_d;
            snap_q     <= snap_d;
            done_q     <= done_d;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        bus.sdo_valid = (state_q != IDLE);
        bus.busy      = (state_q != IDLE);
        bus.sdo       = (state_q != IDLE) & shift_q[7];
        bus.done      = done_q;
    end

endmodule

// File: doc/config_readback.md
CONFIG_READBACK -- requirements
Module: config_readback

Interface
REQ-001 The module SHALL have parameter NREG, default 4, giving the number of 8-bit configuration registers read back (range 1..16).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port cfg_in, input, 8*NREG bits: parallel configuration register outputs; byte k is cfg_in[8k+7:8k].
REQ-005 The module SHALL have port rd_start, input, 1 bit: request to start one readback frame.
REQ-006 The module SHALL have port ser_en, input, 1 bit: serial advance enable; the current bit is consumed on an edge where ser_en=1.
REQ-007 The module SHALL have port sdo, output, 1 bit: serial data, MSB first.
REQ-008 The module SHALL have port sdo_valid, output, 1 bit: high while sdo carries a frame bit.
REQ-009 The module SHALL have port busy, output, 1 bit: high from frame acceptance until frame end.
REQ-010 The module SHALL have port done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-011 The module SHALL implement the FSM states IDLE, HEADER, DATA and CRC.
REQ-012 In IDLE with rd_start=1 at an edge, the module SHALL snapshot cfg_in, load the shift register with 8'hA5, clear the bit counter, clear the CRC and go to HEADER.
REQ-013 In HEADER, DATA and CRC, the module SHALL drive sdo = shift register bit 7 and sdo_valid=1, combinationally from registered state; busy=1.
REQ-014 At an edge with ser_en=1 in a non-IDLE state, the module SHALL shift left by one and increment the 3-bit bit counter; with ser_en=0, state, counters, sdo and the CRC SHALL hold.
REQ-015 After bit 7 of a byte is consumed, the module SHALL transition as follows: HEADER -> DATA with byte 0; DATA byte k -> byte k+1 while k<NREG-1; last DATA byte -> CRC with the final CRC value; CRC -> IDLE.
REQ-016 The byte index SHALL count 0..NREG-1 with no wrap; its width is clog2(NREG), minimum 1 bit.
REQ-017 The CRC SHALL be CRC-8 with polynomial x^8+x^2+x+1 (0x07), init 8'h00, no reflection, no final XOR, computed serially over DATA bits only (header excluded) as each bit is consumed.
REQ-018 The CRC byte loaded SHALL include the last data bit, with no stale-cycle offset.
REQ-019 done SHALL be 1 for exactly one cycle: the cycle after the last CRC bit is consumed, when the state is again IDLE.
REQ-020 A frame SHALL be 8*(NREG+2) consumed bits; with ser_en held at 1, rd_start at edge 0 gives done high after edge 8*(NREG+2).
REQ-021 rd_start while busy=1 SHALL be ignored, with no queuing.
REQ-022 rd_start high in the done cycle SHALL be accepted, giving back-to-back frames with a one-cycle gap.
REQ-023 Changes on cfg_in after the snapshot SHALL NOT affect the current frame.
REQ-024 In IDLE, the module SHALL drive sdo=0 and sdo_valid=0.

Reset
REQ-025 While rstn=0, the module SHALL be in IDLE with sdo=0, sdo_valid=0, busy=0, done=0, shift register, CRC, counters and snapshot at 0, asynchronously, including mid-frame.
REQ-026 After rstn deasserts, the first rd_start SHALL be honoured at the first rising edge at which rd_start=1.

Verification
REQ-027 With NREG=4, cfg_in=32'h00000000 and ser_en=1, a bench SHALL pulse rd_start and see sdo = A5, 00, 00, 00, 00, then CRC 00; 48 valid bits; done one cycle after.
REQ-028 With NREG=4 and cfg_in=32'h00000001, a bench SHALL see data bytes 01, 00, 00, 00 and CRC byte 8'h16.
REQ-029 A bench SHALL toggle ser_en pseudo-randomly and see a bit sequence identical to REQ-028, with sdo held stable whenever ser_en=0.
REQ-030 A bench SHALL pull rstn low at bit 20 and see all outputs 0 immediately; a new rd_start then yields a complete, correct frame.
REQ-031 A bench SHALL assert rd_start at bit 10 and in the done cycle: the first is ignored, and the second starts a new frame with the header on the next cycle.
REQ-032 A bench SHALL change cfg_in to 32'hFFFFFFFF one cycle after acceptance and see the frame still carry the snapshot value.
